// File: rtl/mem_arbiter_if.sv
// Bundle shared by the memory arbiter: two requester ports plus the single BRAM port.
// Handshake: a requester holds reqN and its fields stable until a one-cycle gntN pulse; doneN (one cycle) later marks completion and qualifies rdata.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_rdata,
        output gnt0, gnt1, done0, done1, rdata, busy,
        output bram_en, bram_we, bram_addr, bram_wdata
    );

    // Requesters and BRAM side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_rdata,
        input  gnt0, gnt1, done0, done1, rdata, busy,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered-output BRAM port between two requesters,
// one transaction at a time with fixed-latency gnt/done pulses.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]  state_dbg
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic              ptr;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              win;
    logic              gnt0, gnt1, done0, done1, en, we;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb win = (bus.req0 && bus.req1) ? ptr : bus.req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner   <= win;
                        ptr     <= ~win;
                        we_q    <= win ? bus.we1 : bus.we0;
                        addr_q  <= win ? bus.addr1 : bus.addr0;
                        wdata_q <= win ? bus.wdata1 : bus.wdata0;
                    end
                end
                ISSUE: begin
                    if (!we_q) cnt <= CNT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (cnt == '0) rdata_q <= bus.bram_rdata;
                    else           cnt     <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        en       = 1'b0;
        we       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) state_nx = ISSUE;
            end
            ISSUE: begin
                gnt0     = ~owner;
                gnt1     = owner;
                en       = 1'b1;
                we       = we_q;
                state_nx = we_q ? DONE : WAIT;
            end
            WAIT: begin
                en = 1'b1;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                done0    = ~owner;
                done1    = owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.done0      = done0;
    assign bus.done1      = done1;
    assign bus.bram_en    = en;
    assign bus.bram_we    = we;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_wdata = wdata_q;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = (state != IDLE);
    assign state_dbg      = state;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single synchronous block-RAM port (registered output, fixed read latency) between the SLC-3 CPU memory interface (port 0) and a second requester such as a program loader or debug/DMA port (port 1). It accepts one transaction at a time and sequences the BRAM enable, write-enable and read-capture timing. Each requester gets a fixed-latency, pulse-based grant/done handshake, so neither side has to count BRAM wait states itself.

## Interface
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_LAT, 2, BRAM read latency in cycles from the enabled address cycle to valid bram_rdata (sync read + output register); legal range ≥1.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  transaction request, port 0 (CPU) / port 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, fields captured.
- done0 / done1  out  1  one-cycle pulse: transaction complete; on reads, rdata is valid.
- rdata  out  DATA_W  captured read data, shared by both ports and qualified by doneN.
- busy  out  1  high in any state other than IDLE.
- bram_en  out  1  BRAM port enable; also enables the output register.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req0 or req1 is high, select a winner, latch its we, addr and wdata plus owner id, then go to ISSUE.
  - If neither is high, stay in IDLE.
- Arbitration is round-robin with a 1-bit priority pointer.
  - If only one port requests, that port wins.
  - If both request, the port named by the pointer wins.
  - After each grant the pointer moves to the other port.
  - Reset points it at port 0.
- ISSUE:
  - gnt[owner]=1, bram_en=1, bram_we=we_q, bram_addr=addr_q, bram_wdata=wdata_q.
  - Write: next state DONE.
  - Read: next state WAIT with cnt=RD_LAT-1.
- WAIT:
  - bram_en=1, bram_we=0, bram_addr held at addr_q.
  - cnt decrements each cycle.
  - In the cycle with cnt==0, rdata <= bram_rdata and the FSM moves to DONE.
- DONE:
  - done[owner]=1 for exactly one cycle, then IDLE.
  - rdata holds its value until the next read capture. Writes do not change rdata.
- Requester rules:
  - Hold req and its fields stable until gnt.
  - Deassert req in the cycle after gnt unless issuing a new transaction.
  - A req that is still high in IDLE counts as a new request.
- Outside ISSUE/WAIT: bram_en=0 and bram_we=0. bram_addr and bram_wdata still drive addr_q and wdata_q.
- Only one gnt and one done are asserted at a time. gnt and done never go to a port that is not the owner.

## Timing
- Reset values:
  - state=IDLE, pointer=0, rdata=0, cnt=0.
  - addr_q, wdata_q, we_q and owner are all 0.
  - All gnt, done, bram_en, bram_we and busy outputs are 0.
- The request is sampled in IDLE at cycle T. gnt and the BRAM access both occur at T+1.
- Write: done at T+2, back in IDLE at T+3.
- Read:
  - bram_rdata is valid at T+1+RD_LAT and captured on that edge.
  - done is at T+2+RD_LAT (T+4 with the default RD_LAT), back in IDLE at T+3+RD_LAT.
- With RD_LAT=1, WAIT lasts exactly one cycle.
- Requests that arrive while busy are ignored until IDLE; they are not queued.
- Reset mid-transaction, in any state, takes effect at the next edge. No done pulse is issued for the aborted access, and the pointer returns to port 0.
- Fixed read latency lets the CPU control FSM use exactly RD_LAT+2 wait states per memory access.

## Test plan
- Reset: hold reset 3 cycles while req0=1 → all outputs 0, no gnt, busy=0. First cycle after release → gnt0 next cycle.
- Single read: preload mem[0x0010]=0xBEEF; req0 read 0x0010 at T → gnt0 @T+1, bram_en high T+1..T+3, done0 @T+4, rdata=0xBEEF.
- Single write then read: port1 writes 0x1234 to 0x0020, done1 @T+2 with bram_we high only @T+1. Port0 then reads 0x0020 → 0x1234, and rdata is unchanged across the write.
- Contention: req0 and req1 both held high, read, for 4 transactions → grant order 0,1,0,1. No cycle has both gnt or both done asserted.
- Reset mid-read: assert reset in WAIT → no done0 ever, state IDLE. A subsequent simultaneous req0/req1 grants port 0.
- RD_LAT=1 build: read 0x0003 (=0x00AA) → done @T+3 with rdata=0x00AA.
